mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arb_pkg.sv | 14 +
 rtl/mem_arbiter_if.sv | 48 ++++
 rtl/rr_arbiter2.sv | 19 +
 rtl/mem_arbiter.sv | 122 ++++++++++++
 tb/tb_mem_arbiter.sv | 285 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types for the CPU/debug memory arbiter.
// Holds the FSM state encoding and the owner constants.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_RESP   = 2'd2
  } state_e;

  localparam logic OWNER_CPU = 1'b0;
  localparam logic OWNER_DBG = 1'b1;

endpackage

// File: rtl/mem_arbiter_if.sv
// Bus bundle between requesters, arbiter and shared memory.
// master: requesters + memory side; slave: arbiter side.
interface mem_arbiter_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  logic          cpu_req;
  logic          cpu_rnw;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_wdata;
  logic          cpu_ack;
  logic [DW-1:0] cpu_rdata;
  logic          cpu_stall;
  logic          dbg_req;
  logic          dbg_rnw;
  logic [AW-1:0] dbg_addr;
  logic [DW-1:0] dbg_wdata;
  logic          dbg_ack;
  logic [DW-1:0] dbg_rdata;
  logic          dbg_hold;
  logic          m_sel;
  logic          m_rnw;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_data;
  logic [DW-1:0] s_data;
  logic          busy;
  logic          owner;

  modport slave (
    input  cpu_req, cpu_rnw, cpu_addr, cpu_wdata,
    input  dbg_req, dbg_rnw, dbg_addr, dbg_wdata,
    input  dbg_hold, s_data,
    output cpu_ack, cpu_rdata, cpu_stall,
    output dbg_ack, dbg_rdata,
    output m_sel, m_rnw, m_addr, m_data,
    output busy, owner
  );

  modport master (
    output cpu_req, cpu_rnw, cpu_addr, cpu_wdata,
    output dbg_req, dbg_rnw, dbg_addr, dbg_wdata,
    output dbg_hold, s_data,
    input  cpu_ack, cpu_rdata, cpu_stall,
    input  dbg_ack, dbg_rdata,
    input  m_sel, m_rnw, m_addr, m_data,
    input  busy, owner
  );
endinterface

// File: rtl/rr_arbiter2.sv
// Two-way round-robin pick between CPU and debug.
// Ports: cpu_i/dbg_i eligible reqs, last_i last served, pick_o/any_o.
import mem_arb_pkg::*;

module rr_arbiter2 (
  input  logic cpu_i,
  input  logic dbg_i,
  input  logic last_i,
  output logic pick_o,
  output logic any_o
);

  assign any_o = cpu_i | dbg_i;

  // Debug wins when alone, or on a tie if the CPU went last.
  assign pick_o = dbg_i &
                  (~cpu_i | (last_i == OWNER_CPU));

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates CPU and debug ports onto one shared memory.
// Ports: clk, rst (sync, active high), bus (slave modport).
import mem_arb_pkg::*;

module mem_arbiter #(
  parameter int MEM_LAT = 1,
  parameter int AW      = 32,
  parameter int DW      = 32
) (
  input  logic         clk,
  input  logic         rst,
  mem_arbiter_if.slave bus
);

  localparam logic [3:0] LAST = 4'(MEM_LAT - 1);

  state_e        state_q, state_d;
  logic [3:0]    cnt_q, cnt_d;
  logic          own_q, own_d;
  logic          last_q, last_d;
  logic          rnw_q, rnw_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic [DW-1:0] rdata_q, rdata_d;
  logic          cpu_el, pick, any;
  logic          sel, cack, dack;

  // Held-off CPU requests are simply not eligible.
  assign cpu_el = bus.cpu_req & ~bus.dbg_hold;

  rr_arbiter2 u_rr (
    .cpu_i  (cpu_el),
    .dbg_i  (bus.dbg_req),
    .last_i (last_q),
    .pick_o (pick),
    .any_o  (any)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      own_q   <= OWNER_CPU;
      last_q  <= OWNER_DBG;
      rnw_q   <= 1'b1;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      own_q   <= own_d;
      last_q  <= last_d;
      rnw_q   <= rnw_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    own_d   = own_q;
    last_d  = last_q;
    rnw_d   = rnw_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    unique case (state_q)
      S_IDLE: begin
        if (any) begin
          own_d   = pick;
          cnt_d   = '0;
          state_d = S_ACCESS;
          if (pick == OWNER_DBG) begin
            rnw_d   = bus.dbg_rnw;
            addr_d  = bus.dbg_addr;
            wdata_d = bus.dbg_wdata;
          end else begin
            rnw_d   = bus.cpu_rnw;
            addr_d  = bus.cpu_addr;
            wdata_d = bus.cpu_wdata;
          end
        end
      end
      S_ACCESS: begin
        if (cnt_q == LAST) begin
          if (rnw_q) rdata_d = bus.s_data;
          cnt_d   = '0;
          state_d = S_RESP;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      S_RESP: begin
        last_d  = own_q;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign sel  = (state_q == S_ACCESS);
  assign cack = (state_q == S_RESP) &
                (own_q == OWNER_CPU);
  assign dack = (state_q == S_RESP) &
                (own_q == OWNER_DBG);

  assign bus.m_sel     = sel;
  assign bus.m_rnw     = sel ? rnw_q : 1'b1;
  assign bus.m_addr    = addr_q;
  assign bus.m_data    = wdata_q;
  assign bus.cpu_ack   = cack;
  assign bus.dbg_ack   = dack;
  assign bus.cpu_rdata = cack ? rdata_q : '0;
  assign bus.dbg_rdata = dack ? rdata_q : '0;
  assign bus.cpu_stall = bus.cpu_req & ~cack;
  assign bus.busy      = (state_q != S_IDLE);
  assign bus.owner     = own_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter at MEM_LAT=1 and MEM_LAT=3.
// Stimulus pushes expected transfers; monitors pop on each ack.
module tb_mem_arbiter;

  localparam int L0 = 1;
  localparam int L1 = 3;
  localparam logic [31:0] MASK = 32'hA5A5_0000;

  typedef struct packed {
    logic        own;
    logic        rnw;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int n_tests = 0;
  int n_fail  = 0;

  exp_t q0[$];
  exp_t q1[$];
  int   blen[2];
  logic [31:0] baddr[2];
  bit   pmsel[2];
  bit   mute[2];

  always #5 clk = ~clk;

  mem_arbiter_if #(.AW(32), .DW(32)) b0();
  mem_arbiter_if #(.AW(32), .DW(32)) b1();

  mem_arbiter #(.MEM_LAT(L0), .AW(32), .DW(32)) u0 (
    .clk(clk), .rst(rst), .bus(b0)
  );
  mem_arbiter #(.MEM_LAT(L1), .AW(32), .DW(32)) u1 (
    .clk(clk), .rst(rst), .bus(b1)
  );

  // Simple memory model for the MEM_LAT=3 instance.
  assign b1.s_data = b1.m_addr ^ MASK;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic bad(input string nm);
    n_tests++;
    n_fail++;
    $display("FAIL %s: got event expected none", nm);
  endtask

  task automatic mon(input int id, input int lat,
                     input logic msel, input logic mrnw,
                     input logic [31:0] maddr,
                     input logic [31:0] mdata,
                     input logic cack, input logic [31:0] crd,
                     input logic dack, input logic [31:0] drd,
                     input logic creq, input logic cstall);
    exp_t e;
    bit   emp;
    if (mute[id]) begin
      blen[id]  = 0;
      pmsel[id] = 0;
      return;
    end
    emp = (id == 0) ? (q0.size() == 0) : (q1.size() == 0);
    if (!cack) chk("cpu_rdata_zero", crd, 0);
    if (!dack) chk("dbg_rdata_zero", drd, 0);
    chk("cpu_stall", 32'(cstall), 32'(creq & ~cack));
    if (!msel) chk("m_rnw_idle", 32'(mrnw), 1);
    if (msel) begin
      if (blen[id] == 0) begin
        if (emp) bad("grant_unexpected");
        else begin
          e = (id == 0) ? q0[0] : q1[0];
          chk("m_addr", maddr, e.addr);
          chk("m_rnw", 32'(mrnw), 32'(e.rnw));
          if (!e.rnw) chk("m_data", mdata, e.wdata);
        end
        baddr[id] = maddr;
      end else begin
        chk("m_addr_stable", maddr, baddr[id]);
      end
      blen[id]++;
      chk("ack_during_sel", 32'(cack | dack), 0);
    end
    if (cack | dack) begin
      chk("ack_onehot", 32'(cack & dack), 0);
      chk("burst_len", blen[id], lat);
      chk("ack_after_sel", 32'(pmsel[id]), 1);
      if (emp) bad("ack_unexpected");
      else begin
        e = (id == 0) ? q0.pop_front() : q1.pop_front();
        chk("ack_owner", 32'(dack), 32'(e.own));
        if (e.rnw) chk("rdata", dack ? drd : crd, e.rdata);
      end
      blen[id] = 0;
    end
    pmsel[id] = msel;
  endtask

  always @(negedge clk)
    mon(0, L0, b0.m_sel, b0.m_rnw, b0.m_addr, b0.m_data,
        b0.cpu_ack, b0.cpu_rdata, b0.dbg_ack, b0.dbg_rdata,
        b0.cpu_req, b0.cpu_stall);

  always @(negedge clk)
    mon(1, L1, b1.m_sel, b1.m_rnw, b1.m_addr, b1.m_data,
        b1.cpu_ack, b1.cpu_rdata, b1.dbg_ack, b1.dbg_rdata,
        b1.cpu_req, b1.cpu_stall);

  // Returns at posedge+1 after the ack cycle.
  task automatic wait_ack(input int id, input bit dbg,
                          input int lat_exp);
    int n = 0;
    bit hit = 0;
    while (!hit && n < 60) begin
      @(negedge clk);
      n++;
      if (id == 0) hit = dbg ? b0.dbg_ack : b0.cpu_ack;
      else         hit = dbg ? b1.dbg_ack : b1.cpu_ack;
    end
    if (!hit) bad("ack_timeout");
    else if (lat_exp >= 0) chk("latency", n, lat_exp);
    @(posedge clk);
    #1;
  endtask

  // Returns at posedge+1 after the first m_sel cycle.
  task automatic wait_sel1();
    int n = 0;
    bit hit = 0;
    while (!hit && n < 60) begin
      @(negedge clk);
      n++;
      hit = b1.m_sel;
    end
    if (!hit) bad("msel_timeout");
    @(posedge clk);
    #1;
  endtask

  function automatic exp_t mk(input logic own, input logic rnw,
                              input logic [31:0] a,
                              input logic [31:0] wd,
                              input logic [31:0] rd);
    exp_t e;
    e.own = own; e.rnw = rnw; e.addr = a;
    e.wdata = wd; e.rdata = rd;
    return e;
  endfunction

  initial begin
    int cn, dn, c;
    bit ca, da;
    mute[0] = 1; mute[1] = 1;
    b0.cpu_req = 0; b0.cpu_rnw = 1; b0.cpu_addr = 0;
    b0.cpu_wdata = 0; b0.dbg_req = 0; b0.dbg_rnw = 1;
    b0.dbg_addr = 0; b0.dbg_wdata = 0; b0.dbg_hold = 0;
    b0.s_data = 0;
    b1.cpu_req = 0; b1.cpu_rnw = 1; b1.cpu_addr = 0;
    b1.cpu_wdata = 0; b1.dbg_req = 0; b1.dbg_rnw = 1;
    b1.dbg_addr = 0; b1.dbg_wdata = 0; b1.dbg_hold = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_m_sel", 32'(b0.m_sel), 0);
    chk("rst_m_rnw", 32'(b0.m_rnw), 1);
    chk("rst_busy", 32'(b0.busy), 0);
    chk("rst_owner", 32'(b0.owner), 0);
    chk("rst_cpu_ack", 32'(b0.cpu_ack), 0);
    chk("rst_dbg_ack", 32'(b0.dbg_ack), 0);
    chk("rst_m_addr", b0.m_addr, 0);
    chk("rst_m_data", b0.m_data, 0);
    chk("rst_busy1", 32'(b1.busy), 0);
    chk("rst_m_sel1", 32'(b1.m_sel), 0);
    @(posedge clk); #1;
    rst = 0;
    mute[0] = 0; mute[1] = 0;

    // Single CPU read, MEM_LAT=1
    q0.push_back(mk(0, 1, 32'h10, 0, 32'hDEADBEEF));
    b0.s_data   = 32'hDEADBEEF;
    b0.cpu_addr = 32'h10;
    b0.cpu_rnw  = 1;
    b0.cpu_req  = 1;
    wait_ack(0, 0, L0 + 2);
    b0.cpu_req = 0;

    // Both held: round-robin CPU, DBG, CPU, DBG
    q1.push_back(mk(0, 1, 32'h100, 0, 32'h100 ^ MASK));
    q1.push_back(mk(1, 1, 32'h200, 0, 32'h200 ^ MASK));
    q1.push_back(mk(0, 1, 32'h104, 0, 32'h104 ^ MASK));
    q1.push_back(mk(1, 1, 32'h204, 0, 32'h204 ^ MASK));
    b1.cpu_addr = 32'h100; b1.cpu_rnw = 1; b1.cpu_req = 1;
    b1.dbg_addr = 32'h200; b1.dbg_rnw = 1; b1.dbg_req = 1;
    cn = 0; dn = 0; c = 0;
    while ((cn < 2 || dn < 2) && c < 80) begin
      @(negedge clk);
      ca = b1.cpu_ack;
      da = b1.dbg_ack;
      @(posedge clk); #1;
      c++;
      if (ca) begin
        cn++;
        if (cn < 2) b1.cpu_addr = 32'h104;
        else        b1.cpu_req  = 0;
      end
      if (da) begin
        dn++;
        if (dn < 2) b1.dbg_addr = 32'h204;
        else        b1.dbg_req  = 0;
      end
    end
    if (cn < 2 || dn < 2) bad("rr_timeout");

    // dbg_hold blocks CPU; only debug write served
    q1.push_back(mk(1, 0, 32'h40, 32'hAA, 0));
    q1.push_back(mk(0, 0, 32'h20, 32'h55, 0));
    b1.dbg_hold  = 1;
    b1.cpu_addr  = 32'h20; b1.cpu_wdata = 32'h55;
    b1.cpu_rnw   = 0;      b1.cpu_req   = 1;
    b1.dbg_addr  = 32'h40; b1.dbg_wdata = 32'hAA;
    b1.dbg_rnw   = 0;      b1.dbg_req   = 1;
    wait_ack(1, 1, L1 + 2);
    b1.dbg_req = 0;
    repeat (6) begin
      @(negedge clk);
      chk("hold_m_sel", 32'(b1.m_sel), 0);
      chk("hold_stall", 32'(b1.cpu_stall), 1);
    end
    @(posedge clk); #1;
    b1.dbg_hold = 0;
    wait_ack(1, 0, L1 + 2);
    b1.cpu_req = 0;

    // dbg_hold rising mid-transfer does not abort it
    q1.push_back(mk(0, 1, 32'h60, 0, 32'h60 ^ MASK));
    b1.cpu_addr = 32'h60; b1.cpu_rnw = 1; b1.cpu_req = 1;
    wait_sel1();
    b1.dbg_hold = 1;
    wait_ack(1, 0, -1);
    b1.cpu_req  = 0;
    b1.dbg_hold = 0;

    // Reset in 2nd ACCESS cycle aborts with no ack
    mute[1] = 1;
    b1.cpu_addr = 32'h30; b1.cpu_req = 1;
    wait_sel1();
    rst = 1;
    b1.cpu_req = 0;
    @(posedge clk); #1;
    rst = 0;
    @(negedge clk);
    chk("abort_m_sel", 32'(b1.m_sel), 0);
    chk("abort_busy", 32'(b1.busy), 0);
    repeat (5) begin
      @(negedge clk);
      chk("abort_no_ack", 32'(b1.cpu_ack | b1.dbg_ack), 0);
    end
    mute[1] = 0;
    @(posedge clk); #1;

    // Fresh read; address change mid-burst ignored
    q1.push_back(mk(0, 1, 32'h10, 0, 32'h10 ^ MASK));
    b1.cpu_addr = 32'h10; b1.cpu_req = 1;
    wait_sel1();
    b1.cpu_addr = 32'h99;
    wait_ack(1, 0, -1);
    b1.cpu_req = 0;

    repeat (4) @(posedge clk);
    chk("q_empty", q0.size() + q1.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
